// File: rtl/decoder_2to4_pkg.sv
// Shared types and widths for the 4-to-2 priority encoder block.
// Holds the handshake state enum and the illegal-word predicate.
package decoder_2to4_pkg;

  localparam int CODE_W = 2;
  localparam int REQ_W  = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // A word is illegal unless exactly one request bit is set.
  function automatic logic is_illegal(
    input logic any,
    input logic multi
  );
    return !any || multi;
  endfunction

endpackage

// File: rtl/decoder_2to4_encoder_if.sv
// Request/result bundle between producer, encoder and consumer.
// master drives requests and takes results; slave is the encoder.
interface decoder_2to4_encoder_if #(
  parameter int ERR_CNT_W = 8
);
  import decoder_2to4_pkg::*;

  logic [REQ_W-1:0]     D;
  logic                 in_valid;
  logic                 in_ready;
  logic [CODE_W-1:0]    Y;
  logic                 any;
  logic                 multi;
  logic                 out_valid;
  logic                 out_ready;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output D,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  Y,
    input  any,
    input  multi,
    input  out_valid,
    input  err_count
  );

  modport slave (
    input  D,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output Y,
    output any,
    output multi,
    output out_valid,
    output err_count
  );

endinterface

// File: rtl/priority_enc_4to2.sv
// Combinational 4-to-2 priority encoder, highest set bit wins.
// Also flags empty and multi-hot request words.
module priority_enc_4to2
  import decoder_2to4_pkg::*;
(
  input  logic [REQ_W-1:0]  d,
  output logic [CODE_W-1:0] y,
  output logic              any,
  output logic              multi
);

  always_comb begin
    y = '0;
    priority case (1'b1)
      d[3]:    y = 2'd3;
      d[2]:    y = 2'd2;
      d[1]:    y = 2'd1;
      default: y = 2'd0;
    endcase
  end

  assign any   = |d;
  // Clearing the lowest set bit leaves something only if two were set.
  assign multi = |(d & (d - 1'b1));

endmodule

// File: rtl/decoder_2to4_encoder.sv
// Registered inverse of a 2-to-4 decoder with valid/ready handshakes
// and a saturating count of accepted illegal request words.
module decoder_2to4_encoder
  import decoder_2to4_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  decoder_2to4_encoder_if.slave bus
);

  logic [CODE_W-1:0]    enc_y;
  logic                 enc_any;
  logic                 enc_multi;

  state_t               state;
  logic [CODE_W-1:0]    y_q;
  logic                 any_q;
  logic                 multi_q;
  logic                 valid_q;
  logic [ERR_CNT_W-1:0] err_q;

  logic                 accept;
  logic                 xfer;

  priority_enc_4to2 u_enc (
    .d     (bus.D),
    .y     (enc_y),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // A full slot frees up in the same cycle the consumer takes it.
  assign bus.in_ready = rst_n &&
                        (state == EMPTY || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      y_q     <= '0;
      any_q   <= 1'b0;
      multi_q <= 1'b0;
      err_q   <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state   <= FULL;
            valid_q <= 1'b1;
            y_q     <= enc_y;
            any_q   <= enc_any;
            multi_q <= enc_multi;
          end
        end
        FULL: begin
          if (accept) begin
            y_q     <= enc_y;
            any_q   <= enc_any;
            multi_q <= enc_multi;
          end else if (xfer) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
        end
      endcase

      if (accept && is_illegal(enc_any, enc_multi) &&
          err_q != '1) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign bus.Y         = y_q;
  assign bus.any       = any_q;
  assign bus.multi     = multi_q;
  assign bus.out_valid = valid_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_decoder_2to4_encoder.sv
// Self-checking bench: directed vector table, corner sequences and
// randomized traffic against a behavioural model of the encoder.
module tb_decoder_2to4_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  decoder_2to4_encoder_if #(.ERR_CNT_W(8)) bus ();
  decoder_2to4_encoder_if #(.ERR_CNT_W(2)) bus2 ();

  decoder_2to4_encoder #(.ERR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  decoder_2to4_encoder #(.ERR_CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: index of the highest set bit, computed by counting.
  function automatic int ref_y(input logic [3:0] d);
    int r = 0;
    for (int i = 0; i < 4; i++) if (d[i]) r = i;
    return r;
  endfunction

  function automatic int ref_ones(input logic [3:0] d);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(d[i]);
    return c;
  endfunction

  typedef struct {
    logic [3:0] d;
    logic       v;
    logic       ordy;
    logic       rdy;
    logic       ov;
    int         y;
    logic       any;
    logic       multi;
    int         err;
  } vec_t;

  vec_t tbl[13];

  task automatic drive(input logic [3:0] d, input logic v,
                       input logic ordy);
    bus.D         = d;
    bus.in_valid  = v;
    bus.out_ready = ordy;
  endtask

  task automatic chk_out(input string tag, input logic ov,
                         input int y, input logic a, input logic m,
                         input int err);
    chk({tag, ".out_valid"}, int'(bus.out_valid), int'(ov));
    if (ov) begin
      chk({tag, ".Y"}, int'(bus.Y), y);
      chk({tag, ".any"}, int'(bus.any), int'(a));
      chk({tag, ".multi"}, int'(bus.multi), int'(m));
    end
    chk({tag, ".err_count"}, int'(bus.err_count), err);
  endtask

  // Behavioural model state for the random phase.
  logic       m_held;
  int         m_y;
  logic       m_any;
  logic       m_multi;
  int         m_err;

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    bus2.D = 4'b1111;
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b1;

    // Vector table: inputs applied for one edge, outputs after it.
    tbl[0]  = '{4'b0001, 1, 1, 1, 1, 0, 1, 0, 0};
    tbl[1]  = '{4'b0010, 1, 1, 1, 1, 1, 1, 0, 0};
    tbl[2]  = '{4'b0100, 1, 1, 1, 1, 2, 1, 0, 0};
    tbl[3]  = '{4'b1000, 1, 1, 1, 1, 3, 1, 0, 0};
    tbl[4]  = '{4'b0000, 1, 1, 1, 1, 0, 0, 0, 1};
    tbl[5]  = '{4'b0110, 1, 1, 1, 1, 2, 1, 1, 2};
    tbl[6]  = '{4'b0000, 0, 1, 1, 0, 0, 0, 0, 2};
    tbl[7]  = '{4'b0100, 1, 0, 1, 1, 2, 1, 0, 2};
    tbl[8]  = '{4'b1000, 1, 0, 0, 1, 2, 1, 0, 2};
    tbl[9]  = '{4'b1000, 1, 0, 0, 1, 2, 1, 0, 2};
    tbl[10] = '{4'b1000, 1, 0, 0, 1, 2, 1, 0, 2};
    tbl[11] = '{4'b0001, 1, 1, 1, 1, 0, 1, 0, 2};
    tbl[12] = '{4'b0000, 0, 1, 1, 0, 0, 0, 0, 2};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", int'(bus.in_ready), 0);
    chk_out("rst", 1'b0, 0, 1'b0, 1'b0, 0);
    chk("rst.Y", int'(bus.Y), 0);
    chk("rst.any", int'(bus.any), 0);
    chk("rst.multi", int'(bus.multi), 0);
    rst_n = 1'b1;
    rst2_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].d, tbl[i].v, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d.in_ready", i), int'(bus.in_ready),
          int'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk_out($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].y,
              tbl[i].any, tbl[i].multi, tbl[i].err);
    end

    // Reset while holding a result; accept during reset ignored.
    drive(4'b0011, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_out("prerst", 1'b1, 1, 1'b1, 1'b1, 3);
    rst_n = 1'b0;
    drive(4'b0001, 1'b1, 1'b1);
    #1;
    chk("midrst.in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk_out("midrst", 1'b0, 0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    drive(4'b1000, 1'b1, 1'b1);
    #1;
    chk("postrst.in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    chk_out("postrst", 1'b1, 3, 1'b1, 1'b0, 0);

    // Saturation on the 2-bit counter instance.
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.err_count", i), int'(bus2.err_count),
          (i < 3) ? i + 1 : 3);
      chk($sformatf("sat%0d.Y", i), int'(bus2.Y), 3);
      chk($sformatf("sat%0d.multi", i), int'(bus2.multi), 1);
    end
    bus2.in_valid = 1'b0;

    // Randomized traffic; model starts from a fresh reset.
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    m_held = 1'b0; m_y = 0; m_any = 1'b0; m_multi = 1'b0; m_err = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      logic [3:0] d;
      logic v, o, r, m_rdy, acc;
      if ($urandom_range(1, 0) == 1)
        d = 4'b0001 << $urandom_range(3, 0);
      else
        d = 4'($urandom_range(15, 0));
      v = ($urandom_range(3, 0) != 0);
      o = ($urandom_range(2, 0) != 0);
      r = ($urandom_range(49, 0) != 0);
      rst_n = r;
      drive(d, v, o);
      m_rdy = r && (!m_held || o);
      #1;
      chk($sformatf("rnd%0d.in_ready", c), int'(bus.in_ready),
          int'(m_rdy));
      @(posedge clk);
      acc = v && m_rdy;
      if (!r) begin
        m_held = 1'b0; m_err = 0;
      end else if (acc) begin
        m_held  = 1'b1;
        m_y     = ref_y(d);
        m_any   = (d != 0);
        m_multi = (ref_ones(d) > 1);
        if ((!m_any || m_multi) && m_err < 255) m_err++;
      end else if (m_held && o) begin
        m_held = 1'b0;
      end
      #1;
      chk_out($sformatf("rnd%0d", c), m_held, m_y, m_any, m_multi,
              m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
